// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller.
// Provides FSM state encodings, operand/product widths and their types.
package mult_arb_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef logic [OPW-1:0] opnd_t;
  typedef logic [PW-1:0]  prod_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Client-side bus of the shared multiplier controller.
//   req    : level request per client
//   a_in   : operand X per client, slice i = a_in[8*i+7:8*i]
//   b_in   : operand Y per client, same slicing
//   gnt    : one-hot pulse, operands of that client captured
//   done   : one-hot pulse, result valid for that client
//   result : product, held until the next done
//   busy   : high from the grant cycle through the done cycle
// master = client side, slave = controller side.
interface mult_share_if import mult_arb_pkg::*; #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [OPW*NREQ-1:0] a_in;
  logic [OPW*NREQ-1:0] b_in;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  prod_t               result;
  logic                busy;

  modport master (output req, a_in, b_in, input gnt, done, result, busy);
  modport slave  (input req, a_in, b_in, output gnt, done, result, busy);
endinterface

// File: rtl/mult_share_ctrl_rr_pick.sv
// Combinational round-robin picker.
//   req      : request vector
//   last     : index of the most recently served client
//   pick     : one-hot winner, searching from last+1 with wrap
//   pick_idx : binary index of the winner
//   any_req  : at least one request is present
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] pick_idx,
  output logic                    any_req
);
  localparam int IW = $clog2(NREQ);

  // Walk the priority distance from lowest priority (NREQ) to highest (1),
  // so the nearest requester after last overwrites any farther one.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any_req  = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == (int'(last) + i) % NREQ)) begin
          pick     = '0;
          pick[j]  = 1'b1;
          pick_idx = IW'(j);
          any_req  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multiplier_8bit.sv
// Pipelined unsigned 8x8 multiplier with a fixed latency.
//   clk, rstn : clock, asynchronous active-low reset
//   X, Y      : operands (must be held stable while the result matures)
//   Z         : product, valid LAT sampling edges after X/Y become stable
module multiplier_8bit import mult_arb_pkg::*; #(
  parameter int LAT = 4
) (
  input  logic  clk,
  input  logic  rstn,
  input  opnd_t X,
  input  opnd_t Y,
  output prod_t Z
);

  if (LAT == 1) begin : g_comb
    assign Z = PW'(X) * PW'(Y);
  end else begin : g_pipe
    // LAT-1 register stages: the consumer samples Z on the LAT-th edge.
    prod_t pipe [0:LAT-2];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < LAT-1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= PW'(X) * PW'(Y);
        for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign Z = pipe[LAT-2];
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one multiplier_8bit among NREQ requesters.
//   cclk, rstn : clock, asynchronous active-low reset
//   bus        : client bus (req/a_in/b_in in, gnt/done/result/busy out)
//   mul_x/y    : operands to the shared multiplier
//   mul_z      : product from the shared multiplier
//
// state | meaning
// IDLE  | sample req, round-robin pick, capture operands, pulse gnt
// RUN   | count down the multiplier latency
// DONE  | done pulse to owner, result valid, last busy cycle
module mult_share_ctrl import mult_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int CW   = 3
) (
  input  logic        cclk,
  input  logic        rstn,
  mult_share_if.slave bus,
  output opnd_t       mul_x,
  output opnd_t       mul_y,
  input  prod_t       mul_z
);
  localparam int IW = $clog2(NREQ);

  logic [1:0]      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  prod_t           result_q;
  logic            busy_q;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            any_req;
  logic [NREQ-1:0] owner_oh;
  opnd_t           sel_a;
  opnd_t           sel_b;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (bus.req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        sel_a = bus.a_in[OPW*i +: OPW];
        sel_b = bus.b_in[OPW*i +: OPW];
      end
      if (owner == IW'(i)) owner_oh[i] = 1'b1;
    end
  end

  always_ff @(posedge cclk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= IW'(NREQ-1);
      cnt      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      mul_x    <= '0;
      mul_y    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= pick_idx;
            mul_x  <= sel_a;
            mul_y  <= sel_b;
            gnt_q  <= pick;
            busy_q <= 1'b1;
            cnt    <= CW'(LAT);
            state  <= RUN;
          end
        end
        RUN: begin
          gnt_q <= '0;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result_q <= mul_z;
            done_q   <= owner_oh;
            last     <= owner;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_q  <= '0;
          done_q <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a matched multiplier_8bit.
module tb_mult_share_ctrl;
  import mult_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int CW   = 3;

  logic  cclk = 1'b0;
  logic  rstn = 1'b0;
  opnd_t mul_x, mul_y;
  prod_t mul_z;

  mult_share_if #(.NREQ(NREQ)) bus ();

  mult_share_ctrl #(.NREQ(NREQ), .LAT(LAT), .CW(CW)) dut (
    .cclk  (cclk),
    .rstn  (rstn),
    .bus   (bus),
    .mul_x (mul_x),
    .mul_y (mul_y),
    .mul_z (mul_z)
  );

  multiplier_8bit #(.LAT(LAT)) u_mul (
    .clk  (cclk),
    .rstn (rstn),
    .X    (mul_x),
    .Y    (mul_y),
    .Z    (mul_z)
  );

  always #5 cclk = ~cclk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int    client;
    prod_t product;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int    client;
    opnd_t a;
    opnd_t b;
    prod_t product;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_ops(input int c, input opnd_t a, input opnd_t b);
    bus.a_in[OPW*c +: OPW] = a;
    bus.b_in[OPW*c +: OPW] = b;
  endtask

  task automatic wait_gnt(input string name, output logic [NREQ-1:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    while (g == '0 && cyc < 20) begin
      @(negedge cclk);
      cyc++;
      g = bus.gnt;
    end
    if (g == '0) check({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    @(negedge cclk);
    while (bus.busy && cyc < 20) begin
      @(negedge cclk);
      cyc++;
    end
    if (bus.busy) check({name, "_idle_timeout"}, 32'(1), 32'(0));
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge cclk);
    rstn = 1'b1;
    @(negedge cclk);
  endtask

  // Scoreboard and invariant monitor, sampling on the falling edge.
  always @(negedge cclk) begin
    if (rstn) begin
      if ((bus.gnt | bus.done) != '0) begin
        check("gnt_done_exclusive", 32'(bus.gnt & bus.done), 32'(0));
        check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'(1));
        check("done_onehot", 32'($onehot0(bus.done)), 32'(1));
        check("busy_with_pulse", 32'(bus.busy), 32'(1));
      end
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("done_owner", 32'(bus.done), 32'(1) << mon_e.client);
          check("result", 32'(bus.result), 32'(mon_e.product));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] g;
    int              cyc;
    int              c;

    vecs[0] = '{2, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{1, 8'hFE, 8'h02, 16'h01FC};
    vecs[2] = '{3, 8'h00, 8'h01, 16'h0000};
    vecs[3] = '{0, 8'h80, 8'h80, 16'h4000};
    vecs[4] = '{2, 8'h0F, 8'h11, 16'h00FF};
    vecs[5] = '{1, 8'hAA, 8'h55, 16'h3872};
    vecs[6] = '{1, 8'h01, 8'hFF, 16'h00FF};

    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;

    // 1: reset values, then a single request with exact latency
    rstn = 1'b0;
    repeat (2) @(negedge cclk);
    check("rst_gnt", 32'(bus.gnt), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_result", 32'(bus.result), 32'(0));
    check("rst_mul_x", 32'(mul_x), 32'(0));
    check("rst_mul_y", 32'(mul_y), 32'(0));
    rstn = 1'b1;
    @(negedge cclk);
    check("idle_busy", 32'(bus.busy), 32'(0));

    set_ops(0, 8'd3, 8'd5);
    bus.req = 4'b0001;
    sb.push_back('{0, 16'h000F});
    wait_gnt("t1_gnt", g, cyc);
    check("t1_gnt_value", 32'(g), 32'(4'b0001));
    check("t1_gnt_latency", 32'(cyc), 32'(1));
    check("t1_mul_x", 32'(mul_x), 32'(3));
    check("t1_mul_y", 32'(mul_y), 32'(5));
    bus.req = '0;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge cclk);
      check("t1_done_timing", 32'(bus.done), (n == LAT) ? 32'(1) : 32'(0));
      check("t1_busy", 32'(bus.busy), 32'(1));
    end
    @(negedge cclk);
    check("t1_busy_after", 32'(bus.busy), 32'(0));
    check("t1_done_after", 32'(bus.done), 32'(0));
    check("t1_result_held", 32'(bus.result), 32'(16'h000F));

    // 2: all four requesting, round-robin from client 0 after reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, opnd_t'(i*17), opnd_t'(i*17 + 1));
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      c = k % NREQ;
      sb.push_back('{c, prod_t'((c*17) * (c*17 + 1))});
    end
    for (int k = 0; k < 8; k++) begin
      wait_gnt("t2_gnt", g, cyc);
      check("t2_gnt_order", 32'(g), 32'(1) << (k % NREQ));
      if (k > 0) check("t2_gnt_spacing", 32'(cyc), 32'(LAT + 2));
      if (k == 7) bus.req = '0;
    end
    wait_idle("t2");
    check("t2_sb_empty", 32'(sb.size()), 32'(0));

    // 3: operand table, including arithmetic extremes and a repeating client
    for (int v = 0; v < 7; v++) begin
      set_ops(vecs[v].client, vecs[v].a, vecs[v].b);
      bus.req = 4'(1 << vecs[v].client);
      sb.push_back('{vecs[v].client, vecs[v].product});
      wait_gnt("t3_gnt", g, cyc);
      check("t3_gnt_value", 32'(g), 32'(1) << vecs[v].client);
      check("t3_mul_x", 32'(mul_x), 32'(vecs[v].a));
      check("t3_mul_y", 32'(mul_y), 32'(vecs[v].b));
      bus.req = '0;
      wait_idle("t3");
    end
    check("t3_sb_empty", 32'(sb.size()), 32'(0));

    // 4: reset mid-RUN aborts; pointer returns to its reset value
    set_ops(1, 8'h12, 8'h34);
    bus.req = 4'b0010;
    wait_gnt("t4_gnt", g, cyc);
    check("t4_gnt_value", 32'(g), 32'(4'b0010));
    bus.req = '0;
    @(negedge cclk);
    rstn = 1'b0;
    @(negedge cclk);
    check("t4_rst_busy", 32'(bus.busy), 32'(0));
    check("t4_rst_result", 32'(bus.result), 32'(0));
    check("t4_rst_mul_x", 32'(mul_x), 32'(0));
    check("t4_rst_mul_y", 32'(mul_y), 32'(0));
    @(negedge cclk);
    rstn = 1'b1;
    repeat (LAT + 2) begin
      @(negedge cclk);
      check("t4_no_done", 32'(bus.done), 32'(0));
    end
    check("t4_result_zero", 32'(bus.result), 32'(0));
    set_ops(0, 8'd7, 8'd9);
    set_ops(2, 8'h0B, 8'h0D);
    bus.req = 4'b0101;
    sb.push_back('{0, 16'h003F});
    sb.push_back('{2, 16'h008F});
    wait_gnt("t4_fresh_gnt", g, cyc);
    check("t4_fresh_gnt0", 32'(g), 32'(4'b0001));
    bus.req = 4'b0100;
    wait_gnt("t4_fresh_gnt", g, cyc);
    check("t4_fresh_gnt2", 32'(g), 32'(4'b0100));
    bus.req = '0;
    wait_idle("t4");
    check("t4_sb_empty", 32'(sb.size()), 32'(0));

    // 5: owner drops req after gnt, another client arrives during RUN
    set_ops(1, 8'h21, 8'h03);
    bus.req = 4'b0010;
    sb.push_back('{1, 16'h0063});
    wait_gnt("t5_gnt1", g, cyc);
    check("t5_gnt1_value", 32'(g), 32'(4'b0010));
    bus.req = '0;
    @(negedge cclk);
    set_ops(2, 8'h10, 8'h10);
    bus.req = 4'b0100;
    sb.push_back('{2, 16'h0100});
    wait_gnt("t5_gnt2", g, cyc);
    check("t5_gnt2_value", 32'(g), 32'(4'b0100));
    check("t5_gnt2_delay", 32'(cyc), 32'(LAT + 1));
    bus.req = '0;
    wait_idle("t5");
    check("t5_sb_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
